// File: rtl/uart_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_pkg: parity selectors, transmitter state type and clog2 helper.
// Revision 1.0
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_sync_fifo: single-clock FIFO, show-ahead read, registered pointers/count.
// Revision 1.0
// -----------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (count_q == FULL_COUNT);
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_tx_fifo: queued UART transmitter, configurable width/parity/stop bits.
// Revision 1.0
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [clog2(FIFO_DEPTH):0]    fifo_count
);

  localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'(CLOCK_FREQ / BAUD_RATE);
  localparam int               BIT_W     = 4;
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;

  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   baud_tick;
  logic                   load;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Last en-qualified cycle of the current bit period.
  assign baud_tick = en && (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    if (en) begin
      if (state_q != ST_IDLE) begin
        cnt_d = baud_tick ? '0 : cnt_q + DIV_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          load = !fifo_empty;
        end
        ST_START: begin
          if (baud_tick) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shift_d = shift_q >> 1;
            if (bit_q == LAST_DATA) begin
              bit_d   = '0;
              state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (bit_q == LAST_STOP) begin
              load    = !fifo_empty;
              state_d = ST_IDLE;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      // Frame start: the divisor is captured here and held for the whole frame.
      if (load) begin
        fifo_pop = 1'b1;
        shift_d  = fifo_rdata;
        par_d    = (PARITY == PARITY_ODD) ? ~^fifo_rdata : ^fifo_rdata;
        div_d    = (baud_div != '0) ? baud_div : DEF_DIV;
        state_d  = ST_START;
        bit_d    = '0;
        cnt_d    = '0;
      end
    end
  end

  always_comb begin
    tx_d   = tx_q;
    busy_d = busy_q;
    if (en) begin
      busy_d = (state_q != ST_IDLE);
      case (state_q)
        ST_START:  tx_d = 1'b0;
        ST_DATA:   tx_d = shift_q[0];
        ST_PARITY: tx_d = par_q;
        default:   tx_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= DEF_DIV;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign s_ready = !fifo_full;
  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule
`default_nettype wire
